// File: rtl/bids22defs.sv
// bids22defs: shared types for the bids22 auction engine and its host-side
// command sequencer (opcodes, error codes, sequencer states, FIFO entry).
package bids22defs;

   localparam int OP_W       = 4;
   localparam int ERR_W      = 3;
   localparam int SEQ_DATA_W = 32;

   // Engine opcodes; NO_OP is the idle value driven between commands.
   typedef enum logic [OP_W-1:0] {
      NO_OP      = 4'd0,
      LOCK       = 4'd1,
      UNLOCK     = 4'd2,
      LOADX      = 4'd3,
      LOADY      = 4'd4,
      LOADXDELTA = 4'd5,
      LOADYDELTA = 4'd6,
      CLEAR      = 4'd7
   } opcode_e;

   // Engine error codes reported on cout.err.
   typedef enum logic [ERR_W-1:0] {
      NOERROR         = 3'd0,
      BADOP           = 3'd1,
      ALREADYLOCKED   = 3'd2,
      ALREADYUNLOCKED = 3'd3,
      NOTLOCKED       = 3'd4,
      BADDATA         = 3'd5
   } err_e;

   // Sequencer FSM states.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      ROUND    = 2'd2,
      WAITDONE = 2'd3
   } seq_state_e;

   // One queued host command. The FIFO stores entries flattened in this
   // exact field order ({start, op, data}) so DATAWIDTH can be overridden.
   typedef struct packed {
      logic                  start;
      opcode_e               op;
      logic [SEQ_DATA_W-1:0] data;
   } seq_cmd_t;

endpackage

// File: rtl/bids22_cmd_fifo.sv
// bids22_cmd_fifo: small synchronous show-ahead FIFO of flattened seq_cmd_t
// entries. The head entry is readable combinationally so the sequencer can
// load it onto the engine bus at the same edge it pops it.
module bids22_cmd_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra bit so full and empty can be told apart.
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Guard push/pop against full/empty and advance the pointers.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   // Pointer registers; reset discards everything queued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

   assign head  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/bids22_cmd_sequencer.sv
// bids22_cmd_sequencer: buffers host commands and feeds them to the bids22
// engine control port while the engine is ready, times auction rounds by
// holding C_start, supervises round completion and captures engine errors.
module bids22_cmd_sequencer
   import bids22defs::*;
#(
   parameter int DATAWIDTH = 32,
   parameter int DEPTH     = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 h_valid,
   output logic                 h_ready,
   input  logic                 h_start,
   input  logic [OP_W-1:0]      h_op,
   input  logic [DATAWIDTH-1:0] h_data,
   output logic [OP_W-1:0]      C_op,
   output logic [DATAWIDTH-1:0] C_data,
   output logic                 C_start,
   input  logic                 e_ready,
   input  logic [ERR_W-1:0]     e_err,
   output logic [ERR_W-1:0]     last_err,
   output logic                 err_valid,
   output logic [7:0]           err_count,
   output logic                 round_timeout,
   output logic                 busy
);

   localparam int CMD_W  = 1 + OP_W + DATAWIDTH;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   // FIFO interface
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CMD_W-1:0]     fifo_push_data;
   logic [CMD_W-1:0]     fifo_head;
   logic                 head_start;
   logic [OP_W-1:0]      head_op;
   logic [DATAWIDTH-1:0] head_data;
   logic                 can_pop;
   logic                 err_capture;

   // FSM and round supervision
   seq_state_e           state_q, state_d;
   logic [DATAWIDTH-1:0] round_cnt_q, round_cnt_d;
   logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic                 seen_low_q, seen_low_d;
   logic                 timeout_q, timeout_d;

   // Registered engine bus and error status
   logic [OP_W-1:0]      c_op_q, c_op_d;
   logic [DATAWIDTH-1:0] c_data_q, c_data_d;
   logic                 c_start_q, c_start_d;
   logic [ERR_W-1:0]     last_err_q, last_err_d;
   logic                 err_valid_q, err_valid_d;
   logic [7:0]           err_count_q, err_count_d;

   // Entries are packed {start, op, data}, matching seq_cmd_t.
   assign fifo_push_data = {h_start, h_op, h_data};
   assign head_start     = fifo_head[CMD_W-1];
   assign head_op        = fifo_head[DATAWIDTH +: OP_W];
   assign head_data      = fifo_head[DATAWIDTH-1:0];
   assign fifo_push      = h_valid && !fifo_full;
   assign fifo_pop       = can_pop;

   bids22_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A command may leave the FIFO only between rounds and while the engine is ready.
   always_comb begin
      can_pop = ((state_q == IDLE) || (state_q == ISSUE)) && !fifo_empty && e_ready;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic plus round length and completion-wait counters.
   always_comb begin
      state_d     = state_q;
      round_cnt_d = round_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      seen_low_d  = seen_low_q;
      timeout_d   = 1'b0;
      case (state_q)
         IDLE, ISSUE: begin
            if (can_pop) begin
               if (head_start) begin
                  state_d     = ROUND;
                  // A zero-length round still gets one cycle of C_start.
                  round_cnt_d = (head_data == '0) ? '0 : head_data - DATAWIDTH'(1);
               end else begin
                  state_d = ISSUE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ROUND: begin
            if (round_cnt_q == '0) begin
               state_d    = WAITDONE;
               wait_cnt_d = '0;
               seen_low_d = 1'b0;
            end else begin
               round_cnt_d = round_cnt_q - DATAWIDTH'(1);
            end
         end
         WAITDONE: begin
            // The round is complete once the engine has gone busy and come back.
            if (!e_ready) begin
               seen_low_d = 1'b1;
            end
            if (e_ready && seen_low_q) begin
               state_d = IDLE;
            end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic: next engine bus values and error capture.
   always_comb begin
      c_op_d      = NO_OP;
      c_data_d    = '0;
      c_start_d   = 1'b0;
      case (state_q)
         IDLE, ISSUE: begin
            if (can_pop) begin
               if (head_start) begin
                  c_start_d = 1'b1;
               end else begin
                  c_op_d   = head_op;
                  c_data_d = head_data;
               end
            end
         end
         ROUND: begin
            c_start_d = (round_cnt_q != '0);
         end
         default: begin
            c_start_d = 1'b0;
         end
      endcase

      // Errors are attributed only to cycles where a command or round is on the bus.
      err_capture = ((state_q == ISSUE) || (state_q == ROUND)) && (e_err != NOERROR);
      last_err_d  = err_capture ? e_err : last_err_q;
      err_valid_d = err_capture;
      err_count_d = err_count_q;
      if (err_capture && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   // Datapath registers; reset drops C_start immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         round_cnt_q <= '0;
         wait_cnt_q  <= '0;
         seen_low_q  <= 1'b0;
         timeout_q   <= 1'b0;
         c_op_q      <= NO_OP;
         c_data_q    <= '0;
         c_start_q   <= 1'b0;
         last_err_q  <= NOERROR;
         err_valid_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         round_cnt_q <= round_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         seen_low_q  <= seen_low_d;
         timeout_q   <= timeout_d;
         c_op_q      <= c_op_d;
         c_data_q    <= c_data_d;
         c_start_q   <= c_start_d;
         last_err_q  <= last_err_d;
         err_valid_q <= err_valid_d;
         err_count_q <= err_count_d;
      end
   end

   assign h_ready       = !fifo_full;
   assign busy          = (state_q != IDLE) || !fifo_empty;
   assign C_op          = c_op_q;
   assign C_data        = c_data_q;
   assign C_start       = c_start_q;
   assign last_err      = last_err_q;
   assign err_valid     = err_valid_q;
   assign err_count     = err_count_q;
   assign round_timeout = timeout_q;

endmodule

// File: tb/tb_bids22_cmd_sequencer.sv
// Directed bench for bids22_cmd_sequencer with hand-computed expectations.
module tb_bids22_cmd_sequencer;
   import bids22defs::*;

   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              h_valid;
   logic              h_ready;
   logic              h_start;
   logic [OP_W-1:0]   h_op;
   logic [DW-1:0]     h_data;
   logic [OP_W-1:0]   C_op;
   logic [DW-1:0]     C_data;
   logic              C_start;
   logic              e_ready;
   logic [ERR_W-1:0]  e_err;
   logic [ERR_W-1:0]  last_err;
   logic              err_valid;
   logic [7:0]        err_count;
   logic              round_timeout;
   logic              busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bids22_cmd_sequencer #(
      .DATAWIDTH (DW),
      .DEPTH     (4),
      .TIMEOUT   (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .h_valid       (h_valid),
      .h_ready       (h_ready),
      .h_start       (h_start),
      .h_op          (h_op),
      .h_data        (h_data),
      .C_op          (C_op),
      .C_data        (C_data),
      .C_start       (C_start),
      .e_ready       (e_ready),
      .e_err         (e_err),
      .last_err      (last_err),
      .err_valid     (err_valid),
      .err_count     (err_count),
      .round_timeout (round_timeout),
      .busy          (busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic st, input logic [OP_W-1:0] op, input logic [DW-1:0] d);
      h_valid = 1'b1;
      h_start = st;
      h_op    = op;
      h_data  = d;
      tick();
      $display("push start=%0d op=%0d data=0x%0h", st, op, d);
      h_valid = 1'b0;
      h_start = 1'b0;
      h_op    = NO_OP;
      h_data  = '0;
   endtask

   logic [OP_W-1:0] q_ops [5];
   logic [DW-1:0]   q_dat [5];
   int              high_cnt;
   int              wait_cnt;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      h_valid = 1'b0;
      h_start = 1'b0;
      h_op    = NO_OP;
      h_data  = '0;
      e_ready = 1'b1;
      e_err   = NOERROR;
      q_ops   = '{LOADX, LOADY, LOADXDELTA, LOADYDELTA, LOCK};
      q_dat   = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55};
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check_val("rst_C_op", 32'(C_op), 32'(NO_OP));
      check_val("rst_C_data", C_data, 32'd0);
      check_val("rst_C_start", 32'(C_start), 32'd0);
      check_val("rst_last_err", 32'(last_err), 32'(NOERROR));
      check_val("rst_err_valid", 32'(err_valid), 32'd0);
      check_val("rst_err_count", 32'(err_count), 32'd0);
      check_val("rst_timeout", 32'(round_timeout), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_h_ready", 32'(h_ready), 32'd1);

      // Back-to-back opcode commands
      push_cmd(1'b0, LOADX, 32'd5);
      push_cmd(1'b0, LOCK, 32'hA5);
      check_val("b2b_op0", 32'(C_op), 32'(LOADX));
      check_val("b2b_data0", C_data, 32'd5);
      tick();
      check_val("b2b_op1", 32'(C_op), 32'(LOCK));
      check_val("b2b_data1", C_data, 32'hA5);
      check_val("b2b_busy_mid", 32'(busy), 32'd1);
      tick();
      check_val("b2b_op_idle", 32'(C_op), 32'(NO_OP));
      check_val("b2b_data_idle", C_data, 32'd0);
      check_val("b2b_busy_end", 32'(busy), 32'd0);

      // Round N=3, engine drops ready for two cycles after C_start falls
      push_cmd(1'b1, NO_OP, 32'd3);
      tick();
      check_val("r3_op_noop", 32'(C_op), 32'(NO_OP));
      high_cnt = 0;
      while (C_start && high_cnt < 40) begin
         high_cnt++;
         tick();
      end
      check_val("r3_start_cycles", 32'(high_cnt), 32'd3);
      tick();
      e_ready = 1'b0;
      tick();
      tick();
      e_ready = 1'b1;
      check_val("r3_busy_waiting", 32'(busy), 32'd1);
      tick();
      check_val("r3_busy_done", 32'(busy), 32'd0);
      check_val("r3_no_timeout", 32'(round_timeout), 32'd0);

      // Round N=0 with ready stuck high: one cycle of C_start, then timeout
      push_cmd(1'b1, NO_OP, 32'd0);
      tick();
      high_cnt = 0;
      while (C_start && high_cnt < 40) begin
         high_cnt++;
         tick();
      end
      check_val("r0_start_cycles", 32'(high_cnt), 32'd1);
      wait_cnt = 0;
      while (!round_timeout && wait_cnt < 40) begin
         wait_cnt++;
         tick();
      end
      check_val("to_wait_cycles", 32'(wait_cnt), 32'd16);
      tick();
      check_val("to_pulse_once", 32'(round_timeout), 32'd0);
      check_val("to_busy", 32'(busy), 32'd0);

      // Fill with engine stalled; fifth push must be refused
      e_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         h_valid = 1'b1;
         h_start = 1'b0;
         h_op    = q_ops[i];
         h_data  = q_dat[i];
         check_val($sformatf("full_h_ready%0d", i), 32'(h_ready), (i < 4) ? 32'd1 : 32'd0);
         tick();
      end
      h_valid = 1'b0;
      h_op    = NO_OP;
      h_data  = '0;
      check_val("full_stall_op", 32'(C_op), 32'(NO_OP));
      e_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val($sformatf("drain_op%0d", i), 32'(C_op), 32'(q_ops[i]));
         check_val($sformatf("drain_data%0d", i), C_data, q_dat[i]);
      end
      tick();
      check_val("drain_op_end", 32'(C_op), 32'(NO_OP));
      check_val("drain_busy_end", 32'(busy), 32'd0);

      // Error returned during the UNLOCK cycle
      push_cmd(1'b0, UNLOCK, 32'd0);
      tick();
      check_val("err_unlock_op", 32'(C_op), 32'(UNLOCK));
      e_err = ALREADYUNLOCKED;
      tick();
      e_err = NOERROR;
      check_val("err_last", 32'(last_err), 32'(ALREADYUNLOCKED));
      check_val("err_valid_hi", 32'(err_valid), 32'd1);
      check_val("err_count1", 32'(err_count), 32'd1);
      tick();
      check_val("err_valid_lo", 32'(err_valid), 32'd0);
      check_val("err_count_hold", 32'(err_count), 32'd1);

      // Reset during cycle 2 of an N=5 round with another command queued
      push_cmd(1'b1, NO_OP, 32'd5);
      push_cmd(1'b0, LOADX, 32'd7);
      tick();
      check_val("mid_start_hi", 32'(C_start), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_val("mid_rst_start", 32'(C_start), 32'd0);
      check_val("mid_rst_busy", 32'(busy), 32'd0);
      check_val("mid_rst_h_ready", 32'(h_ready), 32'd1);
      check_val("mid_rst_err_count", 32'(err_count), 32'd0);
      check_val("mid_rst_last_err", 32'(last_err), 32'(NOERROR));
      tick();
      reset = 1'b0;
      tick();
      tick();
      check_val("post_rst_op", 32'(C_op), 32'(NO_OP));
      check_val("post_rst_start", 32'(C_start), 32'd0);
      check_val("post_rst_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bids22_cmd_sequencer.md
# bids22_cmd_sequencer

Host-side command sequencer that sits directly upstream of the bids22 auction engine's control port. It buffers host commands in a small FIFO, drives them onto the engine's `C_op`/`C_data`/`C_start` inputs only while the engine reports ready, and times auction rounds by holding `C_start` for a programmed cycle count. It also captures engine error codes and flags rounds that fail to complete.

## Interface
- `DATAWIDTH`, 32: width of command data and of `C_data`.
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 16: max cycles spent in WAITDONE before `round_timeout`.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `h_valid` in 1: host command valid.
- `h_ready` out 1: sequencer can accept a command; equals `!full`.
- `h_start` in 1: 1 = round command (`h_data` = round length in cycles), 0 = opcode command.
- `h_op` in opcode width: opcode (bids22defs enum); ignored when `h_start`=1.
- `h_data` in DATAWIDTH: opcode data, or round length.
- `C_op` out opcode width: registered opcode to engine.
- `C_data` out DATAWIDTH: registered data to engine.
- `C_start` out 1: registered round-active level to engine.
- `e_ready` in 1: engine ready (`cout.ready`).
- `e_err` in err width: engine error code (`cout.err`).
- `last_err` out err width: most recent non-NOERROR code seen.
- `err_valid` out 1: one-cycle pulse, `last_err` updated.
- `err_count` out 8: saturating count of captured errors.
- `round_timeout` out 1: one-cycle pulse, WAITDONE timed out.
- `busy` out 1: state != IDLE or FIFO non-empty.

## Operation
- FSM states: IDLE, ISSUE, ROUND, WAITDONE.
- Pop condition, evaluated at a rising edge in IDLE or ISSUE: FIFO non-empty and `e_ready`=1.
- Opcode pop: `C_op`/`C_data` load the head entry → ISSUE. The command is driven for exactly one cycle. At the next edge, outputs return to NO_OP/0 unless another pop occurs (back-to-back allowed). If no pop, → IDLE.
- Round pop: `C_start`←1, counter←max(N,1)−1, `C_op`=NO_OP → ROUND. Each edge decrements the counter. At the edge where the counter is 0: `C_start`←0, → WAITDONE. `C_start` is therefore high exactly max(N,1) cycles.
- WAITDONE: sets `seen_low` when `e_ready`=0. Exits to IDLE at the first edge with `e_ready`=1 and `seen_low`. After TIMEOUT cycles with no exit: pulse `round_timeout`, → IDLE.
- Error capture: in ISSUE and ROUND cycles, if `e_err`≠NOERROR at the edge: `last_err`←`e_err`, `err_valid` pulses next cycle, `err_count`++ (saturates at 255). One capture per cycle; a persistent error in ROUND counts every cycle.
- Push: `h_valid && h_ready`. Simultaneous push and pop are both performed. There is no same-cycle bypass; an entry becomes poppable the edge after its push.
- Full FIFO: `h_ready`=0, `h_valid` ignored. Empty FIFO: no pop; engine outputs stay idle.
- Read/write pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.

## Timing
- Reset values: `C_op`=NO_OP, `C_data`=0, `C_start`=0, `last_err`=NOERROR, `err_valid`=0, `err_count`=0, `round_timeout`=0, `busy`=0, `h_ready`=1, FIFO empty, state IDLE.
- Reset asserted mid-round: `C_start` drops asynchronously and queued commands are discarded.
- Latency: push at edge t → earliest `C_op` valid in the cycle after edge t+1.
- `e_ready`=0 stalls pops indefinitely. A command already on the bus is not retracted.
- Throughput: one opcode command per cycle while `e_ready` stays 1.

## Structure
- In bids22defs: the sequencer state enum and an `seq_cmd_t` packed struct {start, op, data}. Opcode and error enums are reused from the package.
- Sub-module `bids22_cmd_fifo`: DEPTH × `seq_cmd_t` synchronous FIFO with full/empty outputs. The FSM, counters and error capture live in the top module.

## Test plan
- Push LOADX/5, then LOCK/0xA5 with `e_ready`=1 → `C_op`=LOADX, `C_data`=5 for one cycle, then LOCK/0xA5 in the next cycle, then NO_OP; `busy` falls after.
- Round with N=3, engine drops `e_ready` 1 cycle after `C_start` falls for 2 cycles → `C_start` high exactly 3 cycles; IDLE the edge after `e_ready` returns.
- Round with N=0 → `C_start` high 1 cycle. Round with `e_ready` stuck at 1 → `round_timeout` pulse after 16 cycles in WAITDONE.
- Push 5 commands with `e_ready`=0 → `h_ready`=0 after 4 pushes, 5th not accepted; release `e_ready` → 4 issued in order.
- Engine returns ALREADYUNLOCKED during the UNLOCK cycle → `last_err`=ALREADYUNLOCKED, `err_valid` pulses once, `err_count`=1.
- Assert `reset` during cycle 2 of an N=5 round → `C_start`=0 immediately, FIFO empty, all outputs at reset values.
